// File: rtl/d_mem_ctrl.sv
// MEM-stage data-memory access controller: issues RV32I loads/stores over a
// req/ack word interface, stalls the pipeline while busy, formats load data.
module d_mem_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        pipe_adv,
  output logic        d_mem_busy,
  output logic [31:0] rdata,
  output logic        access_fault,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_we;
  logic [2:0]       r_funct3;
  logic [31:0]      r_addr, r_wdata, r_rdata;
  logic             r_bus_err;

  logic             w_we, w_legal, w_req, w_fault, w_timeout;
  logic [2:0]       w_funct3;
  logic [31:0]      w_addr, w_wdata;
  logic [1:0]       w_lane;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_ld_data, w_st_wdata;
  logic [3:0]       w_st_be;

  // While waiting the pipeline is frozen, so drive from the captured request.
  assign w_we     = (r_state == WAIT) ? r_we     : req_we;
  assign w_funct3 = (r_state == WAIT) ? r_funct3 : req_funct3;
  assign w_addr   = (r_state == WAIT) ? r_addr   : req_addr;
  assign w_wdata  = (r_state == WAIT) ? r_wdata  : req_wdata;
  assign w_lane   = w_addr[1:0];

  always_comb begin
    w_legal = 1'b0;
    if (req_we) begin
      case (req_funct3)
        3'd0:    w_legal = 1'b1;
        3'd1:    w_legal = ~req_addr[0];
        3'd2:    w_legal = (req_addr[1:0] == 2'b00);
        default: w_legal = 1'b0;
      endcase
    end else begin
      case (req_funct3)
        3'd0, 3'd4: w_legal = 1'b1;
        3'd1, 3'd5: w_legal = ~req_addr[0];
        3'd2:       w_legal = (req_addr[1:0] == 2'b00);
        default:    w_legal = 1'b0;
      endcase
    end
  end

  always_comb begin
    w_byte = mem_rdata[8*w_lane +: 8];
    w_half = w_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (w_funct3)
      3'd0:    w_ld_data = {{24{w_byte[7]}}, w_byte};
      3'd1:    w_ld_data = {{16{w_half[15]}}, w_half};
      3'd4:    w_ld_data = {24'd0, w_byte};
      3'd5:    w_ld_data = {16'd0, w_half};
      default: w_ld_data = mem_rdata;
    endcase
  end

  always_comb begin
    w_st_wdata = 32'd0;
    w_st_be    = 4'b1111;
    if (w_we) begin
      case (w_funct3[1:0])
        2'd0: begin
          w_st_wdata = {4{w_wdata[7:0]}};
          w_st_be    = 4'b0001 << w_lane;
        end
        2'd1: begin
          w_st_wdata = {2{w_wdata[15:0]}};
          w_st_be    = 4'b0011 << w_lane;
        end
        default: begin
          w_st_wdata = w_wdata;
          w_st_be    = 4'b1111;
        end
      endcase
    end
  end

  always_comb begin
    w_next    = r_state;
    w_req     = 1'b0;
    w_fault   = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (w_legal) begin
            w_req  = 1'b1;
            w_next = mem_ack ? DONE : WAIT;
          end else begin
            w_fault = 1'b1;
          end
        end
      end
      WAIT: begin
        w_req = 1'b1;
        if (mem_ack) begin
          w_next = DONE;
        end else if ((TIMEOUT != 0) && (r_cnt == TO_LAST)) begin
          w_timeout = 1'b1;
          w_next    = DONE;
        end
      end
      DONE: begin
        // Holding here keeps a stale request from re-issuing under another stall.
        if (pipe_adv) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_we      <= 1'b0;
      r_funct3  <= 3'd0;
      r_addr    <= 32'd0;
      r_wdata   <= 32'd0;
      r_rdata   <= 32'd0;
      r_bus_err <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_cnt    <= '0;
            if (mem_ack && !req_we) r_rdata <= w_ld_data;
          end
        end
        WAIT: begin
          if (mem_ack) begin
            if (!r_we) r_rdata <= w_ld_data;
          end else if (w_timeout) begin
            r_bus_err <= 1'b1;
            r_rdata   <= 32'd0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (pipe_adv) r_bus_err <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Reset forces every output low immediately, even mid-access.
  assign mem_req      = rst & w_req;
  assign d_mem_busy   = rst & w_req;
  assign mem_we       = rst & w_req & w_we;
  assign mem_addr     = (rst & w_req) ? {w_addr[31:2], 2'b00} : 32'd0;
  assign mem_wdata    = (rst & w_req) ? w_st_wdata : 32'd0;
  assign mem_be       = (rst & w_req) ? w_st_be : 4'd0;
  assign access_fault = rst & w_fault;
  assign rdata        = rst ? r_rdata : 32'd0;
  assign bus_err      = rst & r_bus_err;

endmodule

// File: doc/d_mem_ctrl.md
Name: d_mem_ctrl

Overview:
Data-memory access controller for the MEM stage. It is the producer of the `d_mem_busy` stall request that the pipeline stall logic consumes.
- Takes RV32I load/store requests from the EX/MEM register and drives a variable-latency word memory over a req/ack handshake.
- Holds `d_mem_busy` high until the access completes.
- Returns byte-aligned, sign/zero-extended load data to the MEM/WB path.

Parameters:
- TIMEOUT, 255, max cycles to wait for `mem_ack` before aborting with `bus_err`. 0 disables the timeout.
- CNT_W, 8, width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  1  MEM stage holds a load or store
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- pipe_adv  in  1  MEM stage will latch this edge (stall unit `we_MEM`)
- d_mem_busy  out  1  stall request to stall unit
- rdata  out  32  formatted load result
- access_fault  out  1  misaligned or illegal funct3; no memory access made
- bus_err  out  1  timeout abort flag
- mem_req  out  1  memory request
- mem_we  out  1  memory write
- mem_addr  out  32  word address: `{req_addr[31:2],2'b00}`
- mem_wdata  out  32  lane-replicated store data
- mem_be  out  4  byte enables
- mem_ack  in  1  memory completes request this cycle
- mem_rdata  in  32  read word, valid when `mem_ack`

Behaviour:
- Reset (`rst` = 0): state IDLE, counter 0, `rdata` 0, `bus_err` 0. All outputs are forced to 0 combinationally, including `mem_req` and `d_mem_busy`. Reset mid-access abandons it silently.
- Legality:
  - LH/LHU/SH need `addr[0]` = 0.
  - LW/SW need `addr[1:0]` = 0.
  - funct3 3, 6, 7 (loads) and funct3 > 2 (stores) are illegal.
  - An illegal request raises `access_fault` combinationally in IDLE, with `busy` = 0, no `mem_req`, and no state change.
- States: IDLE, WAIT, DONE.
- IDLE:
  - On `req_valid` and legal: `mem_req` = 1 and `d_mem_busy` = 1 (Mealy), counter cleared.
  - If `mem_ack` is high the same cycle, go to DONE; otherwise go to WAIT.
- WAIT:
  - `mem_req` = 1 and `d_mem_busy` = 1. Address, data and enables are taken from the held request; the pipeline is frozen.
  - On `mem_ack`: go to DONE.
  - Otherwise, if TIMEOUT ≠ 0 and counter = TIMEOUT-1: set `bus_err`, `rdata` = 0, go to DONE.
  - Otherwise increment the counter.
- DONE:
  - `mem_req` = 0, `d_mem_busy` = 0, `rdata` holds the result.
  - Stay in DONE until `pipe_adv` = 1, then go to IDLE. This stops a still-present old request from re-issuing while another stall (e.g. `i_mem_busy`) freezes MEM.
  - `bus_err` clears when leaving DONE.
- Latency: minimum one busy cycle per access (same-cycle ack). N cycles of `mem_ack` delay give N+1 busy cycles.
- Load formatting, latched into `rdata` on the `mem_ack` edge; lane = `addr[1:0]`:
  - LB/LBU: byte `mem_rdata[8*lane +: 8]`, sign/zero-extended.
  - LH/LHU: halfword at lane 0 or 2, sign/zero-extended.
  - LW: full word.
- Store formatting (combinational from the request):
  - SB: `mem_wdata` = `{4{wdata[7:0]}}`, `mem_be` = `4'b0001 << lane`.
  - SH: `mem_wdata` = `{2{wdata[15:0]}}`, `mem_be` = `4'b0011 << lane`.
  - SW: `mem_wdata` = `wdata`, `mem_be` = `4'b1111`.
  - Loads drive `mem_be` = `4'b1111`, `mem_wdata` = 0.
- `mem_we` = `req_we` while `mem_req` is high, else 0.
- `rdata` for stores is left unchanged.
- `req_valid` = 0 in IDLE: idle, all memory outputs 0.
- A `mem_ack` outside WAIT or IDLE-issue is ignored.

Test Plan:
- LW @0x100, `mem_ack` after 3 cycles, `mem_rdata` = 0xDEADBEEF → `d_mem_busy` high 4 cycles, `rdata` = 0xDEADBEEF in DONE, one `mem_req` burst only.
- LB @0x103 with `mem_rdata` = 0x80FF_0000, same-cycle ack → busy 1 cycle, `rdata` = 0xFFFFFF80. Repeat as LBU → 0x00000080. LHU @0x102 → 0x000080FF.
- SH @0x202, `wdata` = 0x1234ABCD → `mem_addr` = 0x200, `mem_be` = 4'b1100, `mem_wdata` = 0xABCDABCD, `mem_we` = 1. SB @0x201 → `mem_be` = 4'b0010.
- LW @0x101 and SH @0x3 → `access_fault` = 1, `d_mem_busy` = 0, `mem_req` never asserted.
- Ack at cycle 1, `pipe_adv` held 0 for 3 cycles with `req_valid` still high → stays DONE, no second `mem_req`. `pipe_adv` = 1 → IDLE, next request issues.
- TIMEOUT = 4, no ack → `bus_err` = 1 after 4 WAIT cycles, `rdata` = 0. Separately, `rst` low in WAIT → `mem_req` and `d_mem_busy` drop immediately, state IDLE.
